// File: rtl/exec_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops and a 16-step shift-add
// multiply, writing back to the register file with a one-cycle load strobe.
module exec_unit #(
   parameter int WIDTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [AW-1:0]    dst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic [AW-1:0]    Caddr,
   output logic             load,
   output logic [3:0]       flags
);

   // state | meaning
   // IDLE  | waiting for start; operands latched on accept
   // EXEC  | single-cycle ALU op, result/flags registered on exit
   // MUL   | shift-add multiply, one multiplier bit per cycle, LSB first
   // WB    | load/done strobe for exactly one cycle
   typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   a_r, b_r;
   logic [3:0]         op_r;
   logic [AW-1:0]      dst_r;
   logic [2*WIDTH-1:0] prod_r, mcand_r, mul_sum;
   logic [WIDTH-1:0]   mplier_r;
   logic [3:0]         cnt_r;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;
   logic [WIDTH:0]     ext;
   logic [3:0]         sh;
   logic               is_nop;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (opcode == OP_MUL) ? MUL : EXEC;
         EXEC:    state_nxt = WB;
         MUL:     if (cnt_r == 4'd15) state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign done   = (state == WB);
   assign is_nop = (op_r > OP_MUL);
   assign load   = (state == WB) && !is_nop;
   assign sh     = b_r[3:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      ext     = '0;
      case (op_r)
         OP_PASS: alu_res = a_r;
         OP_ADD: begin
            ext     = {1'b0, a_r} + {1'b0, b_r};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = ~(a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (alu_res[WIDTH-1] ^ a_r[WIDTH-1]);
         end
         OP_SUB: begin
            // bit WIDTH of the extended difference is the unsigned borrow
            ext     = {1'b0, a_r} - {1'b0, b_r};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (alu_res[WIDTH-1] ^ a_r[WIDTH-1]);
         end
         OP_AND: alu_res = a_r & b_r;
         OP_OR:  alu_res = a_r | b_r;
         OP_XOR: alu_res = a_r ^ b_r;
         OP_NOT: alu_res = ~a_r;
         OP_SHL: begin
            ext     = {1'b0, a_r} << sh;
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
         end
         OP_SHR: begin
            // a guard bit below the LSB catches the last bit shifted out
            ext     = {a_r, 1'b0} >> sh;
            alu_res = ext[WIDTH:1];
            alu_c   = ext[0];
         end
         default: ;
      endcase
   end

   assign mul_sum = prod_r + (mplier_r[0] ? mcand_r : '0);

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= '0;
         dst_r    <= '0;
         prod_r   <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         cnt_r    <= '0;
         C        <= '0;
         Caddr    <= '0;
         flags    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r      <= A;
               b_r      <= B;
               op_r     <= opcode;
               dst_r    <= dst;
               prod_r   <= '0;
               mcand_r  <= {{WIDTH{1'b0}}, A};
               mplier_r <= B;
               cnt_r    <= '0;
            end
            EXEC: if (!is_nop) begin
               C     <= alu_res;
               Caddr <= dst_r;
               flags <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
            MUL: begin
               prod_r   <= mul_sum;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + 4'd1;
               if (cnt_r == 4'd15) begin
                  C     <= mul_sum[WIDTH-1:0];
                  Caddr <= dst_r;
                  flags <= {mul_sum[WIDTH-1], (mul_sum[WIDTH-1:0] == '0),
                            (|mul_sum[2*WIDTH-1:WIDTH]), 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit: latency, results, flags, busy/ignore, clear.
module tb_exec_unit;

   logic        clk, clear, start;
   logic [3:0]  opcode, dst;
   logic [15:0] A, B;
   logic        busy, done, load;
   logic [15:0] C;
   logic [3:0]  Caddr, flags;

   int n_vec = 0;
   int n_err = 0;

   exec_unit #(.WIDTH(16), .AW(4)) dut (
      .clk(clk), .clear(clear), .start(start), .opcode(opcode), .dst(dst),
      .A(A), .B(B), .busy(busy), .done(done), .C(C), .Caddr(Caddr),
      .load(load), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, scramble inputs after accept, return edges from accept to done.
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, output int lat);
      @(negedge clk);
      opcode = op; A = a; B = b; dst = d; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; opcode = 4'd1; dst = ~d;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   int          lat;
   logic        load_seen;
   logic [31:0] exp_busy [6] = '{1, 1, 0, 1, 1, 0};
   logic [31:0] exp_load [6] = '{0, 1, 0, 0, 1, 0};

   initial begin
      clear = 1'b1; start = 1'b0; opcode = '0; dst = '0; A = '0; B = '0;
      @(negedge clk);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_done",  32'(done),  0);
      chk("rst_load",  32'(load),  0);
      chk("rst_C",     32'(C),     0);
      chk("rst_Caddr", 32'(Caddr), 0);
      chk("rst_flags", 32'(flags), 0);
      clear = 1'b0;

      // ADD overflow
      issue(4'd1, 16'h7FFF, 16'h0001, 4'd3, lat);
      chk("add_lat",   32'(lat),   1);
      chk("add_load",  32'(load),  1);
      chk("add_C",     32'(C),     32'h8000);
      chk("add_Caddr", 32'(Caddr), 3);
      chk("add_flags", 32'(flags), 32'b1001);
      @(negedge clk);
      chk("add_load_drop", 32'(load), 0);
      chk("add_done_drop", 32'(done), 0);
      chk("add_busy_drop", 32'(busy), 0);

      // SUB borrow, then zero
      issue(4'd2, 16'd5, 16'd7, 4'd1, lat);
      chk("sub_C",     32'(C),     32'hFFFE);
      chk("sub_flags", 32'(flags), 32'b1010);
      issue(4'd2, 16'h1234, 16'h1234, 4'd1, lat);
      chk("subz_C",     32'(C),     0);
      chk("subz_flags", 32'(flags), 32'b0100);

      // MUL
      issue(4'd9, 16'h0123, 16'h0045, 4'd15, lat);
      chk("mul_lat",   32'(lat),   16);
      chk("mul_load",  32'(load),  1);
      chk("mul_C",     32'(C),     32'h4E6F);
      chk("mul_Caddr", 32'(Caddr), 15);
      chk("mul_flags", 32'(flags), 32'b0000);
      issue(4'd9, 16'h0100, 16'h0100, 4'd2, lat);
      chk("mulz_C",     32'(C),     0);
      chk("mulz_flags", 32'(flags), 32'b0110);

      // NOP holds C/Caddr/flags
      issue(4'd12, 16'hAAAA, 16'h5555, 4'd9, lat);
      chk("nop_done",  32'(done),  1);
      chk("nop_load",  32'(load),  0);
      chk("nop_C",     32'(C),     0);
      chk("nop_Caddr", 32'(Caddr), 2);
      chk("nop_flags", 32'(flags), 32'b0110);

      // Shifts and a few logic ops
      issue(4'd7, 16'h8001, 16'd1, 4'd4, lat);
      chk("shl_C",     32'(C),     32'h0002);
      chk("shl_flags", 32'(flags), 32'b0010);
      issue(4'd8, 16'h8001, 16'd15, 4'd5, lat);
      chk("shr_C",     32'(C),     32'h0001);
      chk("shr_flags", 32'(flags), 32'b0000);
      issue(4'd7, 16'h8001, 16'd0, 4'd5, lat);
      chk("shl0_flags", 32'(flags), 32'b1000);
      issue(4'd6, 16'h00FF, 16'h0000, 4'd6, lat);
      chk("not_C",     32'(C),     32'hFF00);
      chk("not_flags", 32'(flags), 32'b1000);
      issue(4'd5, 16'hF0F0, 16'hFF00, 4'd7, lat);
      chk("xor_C", 32'(C), 32'h0FF0);
      issue(4'd0, 16'h4321, 16'hFFFF, 4'd8, lat);
      chk("pass_C", 32'(C), 32'h4321);

      // start held high across two ADDs
      @(negedge clk);
      opcode = 4'd1; A = 16'd1; B = 16'd2; dst = 4'd10; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      A = 16'd10; B = 16'd20;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 4) start = 1'b0;
         chk($sformatf("b2b_busy_%0d", k), 32'(busy), exp_busy[k]);
         chk($sformatf("b2b_load_%0d", k), 32'(load), exp_load[k]);
         if (k == 1) chk("b2b_C1", 32'(C), 3);
         if (k == 4) chk("b2b_C2", 32'(C), 30);
      end

      // clear mid-MUL
      @(negedge clk);
      opcode = 4'd9; A = 16'hFFFF; B = 16'hFFFF; dst = 4'd11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_busy", 32'(busy), 1);
      clear = 1'b1;
      #1;
      chk("clr_busy",  32'(busy),  0);
      chk("clr_done",  32'(done),  0);
      chk("clr_load",  32'(load),  0);
      chk("clr_flags", 32'(flags), 0);
      chk("clr_C",     32'(C),     0);
      @(negedge clk);
      clear = 1'b0;
      load_seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (load || done) load_seen = 1'b1;
      end
      chk("clr_no_load", 32'(load_seen), 0);
      chk("clr_Caddr",   32'(Caddr),     0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
